// File: rtl/student_coeff_tl_writer.sv
// TL-UL host that streams FIR coefficients into a coefficient RAM: one PutFullData
// per coefficient at consecutive word addresses, one transaction outstanding at a time.
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [6:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_coeff_tl_writer
  import tlul_pkg::*;
#(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned CoeffDataSize = 16,
  parameter logic [31:0] BaseAddr      = 32'h0000_0000,
  parameter logic [7:0]  SourceId      = 8'h00
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [AddrWidth:0]       num_i,
  input  logic                     coeff_valid_i,
  input  logic [CoeffDataSize-1:0] coeff_data_i,
  output logic                     coeff_ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output tl_h2d_t                  tl_o,
  input  tl_d2h_t                  tl_i
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // valid never depends on ready, and payload holds steady while valid waits for ready.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StReq,
    StResp,
    StFin
  } state_e;

  localparam logic [AddrWidth:0] One = 1;

  state_e                   state_q, state_d;
  logic [AddrWidth:0]       count_q, count_d;
  logic [AddrWidth:0]       index_q, index_d;
  logic [CoeffDataSize-1:0] coeff_q, coeff_d;
  logic                     err_q, err_d;
  logic [31:0]              index_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      index_q <= '0;
      coeff_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      coeff_q <= coeff_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    coeff_d = coeff_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d = num_i;
          index_d = '0;
          err_d   = 1'b0;
          state_d = (num_i == '0) ? StFin : StFetch;
        end
      end
      StFetch: begin
        if (coeff_valid_i) begin
          coeff_d = coeff_data_i;
          state_d = StReq;
        end
      end
      StReq: begin
        if (tl_i.a_ready) state_d = StResp;
      end
      StResp: begin
        // A failed write is recorded but the sequence keeps going to the last index.
        if (tl_i.d_valid) begin
          if (tl_i.d_error || (tl_i.d_opcode != AccessAck)) err_d = 1'b1;
          index_d = index_q + One;
          state_d = ((index_q + One) == count_q) ? StFin : StFetch;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign index_ext = 32'(index_q[AddrWidth-1:0]);

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == StReq);
    tl_o.a_opcode  = PutFullData;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = BaseAddr + (index_ext << 2);
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = 32'(coeff_q);
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = (state_q == StResp);
  end

  assign coeff_ready_o = (state_q == StFetch);
  assign busy_o        = (state_q == StFetch) || (state_q == StReq) || (state_q == StResp);
  assign done_o        = (state_q == StFin);
  assign err_o         = err_q;

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                       tl_i.d_data, tl_i.d_user, index_q[AddrWidth]};

endmodule
